// File: rtl/call_stack_if.sv
// Control-flow bus between the decode stage and the call stack.
// Op semantics: call/ret/jmp/jmpz are single-cycle strobes qualified only by
// the clock. There is no valid/ready handshake because the stack always
// accepts an op. jmp_en/jmp_addr answer combinationally in the same cycle.
// Stack state, depth and the error flags change on the rising edge.
interface call_stack_if #(
  parameter int AW         = 8,
  parameter int DEPTH_LOG2 = 3
);
  logic [AW-1:0]         pc;
  logic                  call;
  logic                  ret;
  logic                  jmp;
  logic                  jmpz;
  logic                  zero;
  logic [AW-1:0]         target;
  logic                  err_clr;
  logic                  jmp_en;
  logic [AW-1:0]         jmp_addr;
  logic [DEPTH_LOG2:0]   depth;
  logic                  full;
  logic                  empty;
  logic                  ovf;
  logic                  unf;

  // Decode side: issues ops, observes redirect and stack status.
  modport master (
    output pc, call, ret, jmp, jmpz, zero, target, err_clr,
    input  jmp_en, jmp_addr, depth, full, empty, ovf, unf
  );

  // Call stack side.
  modport slave (
    input  pc, call, ret, jmp, jmpz, zero, target, err_clr,
    output jmp_en, jmp_addr, depth, full, empty, ovf, unf
  );
endinterface

// File: rtl/call_stack.sv
// Control-flow resolver and return-address LIFO beside the program counter.
// The redirect is combinational so the pc can take it on its falling edge in
// the same cycle. Pushes, pops and the sticky error flags update on the rising
// edge. Op priority is ret > call > jmp > jmpz. Lower ops are fully ignored.
module call_stack #(
  parameter int AW         = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic         clk,
  input  logic         rst,
  call_stack_if.slave  bus
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [AW-1:0]         stack [DEPTH];
  logic [DEPTH_LOG2:0]   depth_q;
  logic                  ovf_q;
  logic                  unf_q;

  logic                  is_full;
  logic                  is_empty;
  logic [DEPTH_LOG2-1:0] top_idx;
  logic [DEPTH_LOG2-1:0] push_idx;
  logic [AW-1:0]         top_addr;
  logic                  do_push;
  logic                  do_pop;
  logic                  call_blocked;
  logic                  ret_blocked;
  logic                  redir_en;
  logic [AW-1:0]         redir_addr;

  assign is_full  = (depth_q == (DEPTH_LOG2 + 1)'(DEPTH));
  assign is_empty = (depth_q == '0);
  // Only read when not empty, so the wrap at depth 0 is never observed.
  assign top_idx  = DEPTH_LOG2'(depth_q - 1'b1);
  // Only used when not full, so depth fits in the index width.
  assign push_idx = depth_q[DEPTH_LOG2-1:0];
  assign top_addr = stack[top_idx];

  // A call only counts when no ret shares the cycle.
  assign do_pop       = bus.ret & ~is_empty;
  assign ret_blocked  = bus.ret & is_empty;
  assign do_push      = bus.call & ~bus.ret & ~is_full;
  assign call_blocked = bus.call & ~bus.ret & is_full;

  // Resolve the redirect from the highest-priority op present.
  always_comb begin
    redir_en   = 1'b0;
    redir_addr = '0;
    if (bus.ret) begin
      if (!is_empty) begin
        redir_en   = 1'b1;
        redir_addr = top_addr;
      end
    end else if (bus.call) begin
      if (!is_full) begin
        redir_en   = 1'b1;
        redir_addr = bus.target;
      end
    end else if (bus.jmp) begin
      redir_en   = 1'b1;
      redir_addr = bus.target;
    end else if (bus.jmpz) begin
      if (bus.zero) begin
        redir_en   = 1'b1;
        redir_addr = bus.target;
      end
    end
  end

  // Redirect is forced quiet while reset is held.
  assign bus.jmp_en   = rst & redir_en;
  assign bus.jmp_addr = rst ? redir_addr : '0;
  assign bus.depth    = depth_q;
  assign bus.full     = is_full;
  assign bus.empty    = is_empty;
  assign bus.ovf      = ovf_q;
  assign bus.unf      = unf_q;

  // Stack storage: write the return address (pc+1, wrapping) on a push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else if (do_push) begin
      stack[push_idx] <= bus.pc + 1'b1;
    end
  end

  // Occupancy counter: push and pop are mutually exclusive by priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      depth_q <= '0;
    end else if (do_push) begin
      depth_q <= depth_q + 1'b1;
    end else if (do_pop) begin
      depth_q <= depth_q - 1'b1;
    end
  end

  // Sticky error flags: a new event in the clear cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~bus.err_clr) | call_blocked;
      unf_q <= (unf_q & ~bus.err_clr) | ret_blocked;
    end
  end

endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- Control-flow resolver and return-address stack that sits beside the program counter.
- Consumes the current pc and decoded control-flow ops (call, ret, jmp, jmpz).
- Produces the jmp_en/jmp_addr pair that the program counter samples on its falling clock edge.
- Holds nested return addresses in a small LIFO and reports overflow/underflow.

Parameters:
- AW, 8, program-address width (matches pc/jmp_addr).
- DEPTH_LOG2, 3, log2 of stack depth; DEPTH = 2**DEPTH_LOG2 = 8 entries.

Ports:
- clk  in  1  system clock; stack state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc  in  AW  current program counter (stable around the rising edge).
- call  in  1  call op this cycle.
- ret  in  1  return op this cycle.
- jmp  in  1  unconditional jump op this cycle.
- jmpz  in  1  jump-if-zero op this cycle.
- zero  in  1  ALU zero flag, qualifies jmpz.
- target  in  AW  jump/call destination.
- err_clr  in  1  clears sticky error flags.
- jmp_en  out  1  redirect request to program counter.
- jmp_addr  out  AW  redirect address.
- depth  out  DEPTH_LOG2+1  number of valid entries, 0..DEPTH.
- full  out  1  depth == DEPTH.
- empty  out  1  depth == 0.
- ovf  out  1  sticky: call attempted while full.
- unf  out  1  sticky: ret attempted while empty.

Behaviour:
- rst low (any time, asynchronous): depth=0, all entries cleared to 0, ovf=0, unf=0. Outputs while in reset: jmp_en=0, jmp_addr=0, empty=1, full=0.
- A reset mid-sequence discards all stacked addresses.
- jmp_en/jmp_addr are combinational from the ops, zero, target, pc and stack top. No registered latency: a redirect takes effect at the program counter's next falling edge in the same cycle.
- Stack, depth and flags update on the rising edge.
- Op priority when more than one is asserted: ret > call > jmp > jmpz. Lower-priority ops in that cycle are ignored entirely, with no side effects.
- ret, not empty:
  - jmp_en=1, jmp_addr=stack[depth-1].
  - On the rising edge, depth decrements.
- ret, empty:
  - jmp_en=0, jmp_addr=0; pc continues sequentially.
  - On the rising edge, unf<=1; depth stays 0.
- call, not full:
  - jmp_en=1, jmp_addr=target.
  - On the rising edge, stack[depth]<=pc+1 (AW-bit wrap: 8'hFF pushes 8'h00) and depth increments.
- call, full:
  - Call is suppressed: jmp_en=0, no push.
  - On the rising edge, ovf<=1; the stack is unchanged.
- jmp: jmp_en=1, jmp_addr=target; stack unchanged.
- jmpz: jmp_en=zero, jmp_addr=target when zero=1, else 0; stack unchanged.
- No op asserted: jmp_en=0, jmp_addr=0.
- err_clr: on the rising edge, clears ovf and unf. A new error event in the same cycle wins, so the flag stays or becomes 1.
- full/empty are derived combinationally from the registered depth.
- Entries above depth retain stale data and are never observable.

Test Plan:
- Reset then idle: rst=0 -> jmp_en=0, depth=0, empty=1, ovf=unf=0. Release rst, no ops for 5 cycles -> all unchanged.
- Call/return pair: pc=8'h10, call=1, target=8'h40 -> jmp_en=1, jmp_addr=8'h40, depth=1 after edge. Later pc=8'h45, ret=1 -> jmp_en=1, jmp_addr=8'h11, depth=0.
- Nesting to full and overflow:
  - 8 calls from pc=8'h00..8'h07 -> depth=8, full=1.
  - 9th call -> jmp_en=0, ovf=1, depth=8.
  - 8 rets -> jmp_addr sequence 8'h08,8'h07..8'h01, then empty=1.
- Underflow and clear:
  - ret with empty -> jmp_en=0, unf=1.
  - err_clr=1 next cycle -> unf=0.
  - err_clr=1 with ret on empty in the same cycle -> unf stays 1.
- Wrap and conditional:
  - call at pc=8'hFF -> pushed 8'h00; later ret -> jmp_addr=8'h00.
  - jmpz with zero=0 -> jmp_en=0; jmpz with zero=1, target=8'h22 -> jmp_en=1, jmp_addr=8'h22.
- Priority and async reset:
  - call+ret together with depth=2, top=8'h31 -> jmp_addr=8'h31, depth=1, no push.
  - Assert rst mid-cycle between edges -> depth=0 immediately, without waiting for a clock edge.
